// File: rtl/tmr_alu_voted_core.sv
// Triple-modular-redundant ALU: serial frame loader, three isolated replica datapaths,
// registered bitwise majority vote with per-replica error flags and a saturating error counter.
module tmr_alu_voted_core #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DATA_IN,
  input  logic                 READY,
  input  logic                 CNT_CLR,
  input  logic [2:0]           FAULT_EN,
  input  logic [WIDTH-1:0]     FAULT_MASK,
  output logic                 BUSY,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT,
  output logic [2*WIDTH-1:0]   OUT_MUL,
  output logic                 COUT,
  output logic [2:0]           REP_ERR,
  output logic                 MULTI_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);
  localparam int FRAME_LEN = 2*WIDTH + 3;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam int SHW       = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC, VOTE} state_t;

  state_t                 state;
  logic [FRAME_LEN-1:0]   frame;
  logic [CW-1:0]          bit_cnt;

  logic [WIDTH-1:0]       rep_out [3];
  logic [2*WIDTH-1:0]     rep_mul [3];
  logic [2:0]             rep_c;

  logic [WIDTH-1:0]       v_out;
  logic [2*WIDTH-1:0]     v_mul;
  logic                   v_c;
  logic [2:0]             err;

  // Frame enters at the MSB and shifts down, so after FRAME_LEN bits bit 0 sits at frame[0].
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      frame   <= '0;
      bit_cnt <= '0;
      BUSY    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (READY) begin
            frame   <= {DATA_IN, frame[FRAME_LEN-1:1]};
            bit_cnt <= CW'(1);
            state   <= SHIFT;
            BUSY    <= 1'b1;
          end
        end
        SHIFT: begin
          frame   <= {DATA_IN, frame[FRAME_LEN-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(FRAME_LEN-1)) state <= EXEC;
        end
        EXEC: state <= VOTE;
        VOTE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rep
    logic [WIDTH-1:0]   a, b, r;
    logic [2:0]         op;
    logic [2*WIDTH-1:0] prod;
    logic               c;
    (* keep = "true" *) logic [WIDTH-1:0]   q_out;
    (* keep = "true" *) logic [2*WIDTH-1:0] q_mul;
    (* keep = "true" *) logic               q_c;

    assign a  = frame[WIDTH-1:0];
    assign b  = frame[2*WIDTH-1:WIDTH];
    assign op = frame[2*WIDTH+2:2*WIDTH];

    always_comb begin
      r    = '0;
      prod = '0;
      c    = 1'b0;
      case (op)
        3'b000:  {c, r} = {1'b0, a} + {1'b0, b};
        3'b001: begin
          r = a - b;
          c = (a < b);
        end
        3'b010:  r = a & b;
        3'b011:  r = a | b;
        3'b100:  r = a ^ b;
        3'b101:  r = ~a;
        3'b110:  r = a << b[SHW-1:0];
        default: begin
          prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
          r    = prod[WIDTH-1:0];
        end
      endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_out <= '0;
        q_mul <= '0;
        q_c   <= 1'b0;
      end else if (state == EXEC) begin
        q_out <= FAULT_EN[g] ? (r ^ FAULT_MASK) : r;
        q_mul <= prod;
        q_c   <= c;
      end
    end

    assign rep_out[g] = q_out;
    assign rep_mul[g] = q_mul;
    assign rep_c[g]   = q_c;
  end

  always_comb begin
    v_out = (rep_out[0] & rep_out[1]) | (rep_out[0] & rep_out[2]) | (rep_out[1] & rep_out[2]);
    v_mul = (rep_mul[0] & rep_mul[1]) | (rep_mul[0] & rep_mul[2]) | (rep_mul[1] & rep_mul[2]);
    v_c   = (rep_c[0] & rep_c[1]) | (rep_c[0] & rep_c[2]) | (rep_c[1] & rep_c[2]);
    err   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      err[i] = (|(rep_out[i] ^ v_out)) | (|(rep_mul[i] ^ v_mul)) | (rep_c[i] ^ v_c);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      OUT_MUL   <= '0;
      COUT      <= 1'b0;
      REP_ERR   <= '0;
      MULTI_ERR <= 1'b0;
    end else begin
      OUT_VALID <= (state == VOTE);
      if (state == VOTE) begin
        OUT       <= v_out;
        OUT_MUL   <= v_mul;
        COUT      <= v_c;
        REP_ERR   <= err;
        MULTI_ERR <= (err[0] & err[1]) | (err[0] & err[2]) | (err[1] & err[2]);
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_CNT <= '0;
    end else if (CNT_CLR) begin
      ERR_CNT <= '0;
    end else if ((state == VOTE) && (err != 3'b000) && (ERR_CNT != '1)) begin
      ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_tmr_alu_voted_core.sv
// Directed bench for tmr_alu_voted_core at WIDTH=16, ERR_CNT_W=8.
module tb_tmr_alu_voted_core;
  localparam int W  = 16;
  localparam int FL = 2*W + 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          DATA_IN;
  logic          READY;
  logic          CNT_CLR;
  logic [2:0]    FAULT_EN;
  logic [W-1:0]  FAULT_MASK;
  logic          BUSY;
  logic          OUT_VALID;
  logic [W-1:0]  OUT;
  logic [2*W-1:0] OUT_MUL;
  logic          COUT;
  logic [2:0]    REP_ERR;
  logic          MULTI_ERR;
  logic [7:0]    ERR_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_alu_voted_core #(.WIDTH(W), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .READY(READY), .CNT_CLR(CNT_CLR),
    .FAULT_EN(FAULT_EN), .FAULT_MASK(FAULT_MASK), .BUSY(BUSY), .OUT_VALID(OUT_VALID),
    .OUT(OUT), .OUT_MUL(OUT_MUL), .COUT(COUT), .REP_ERR(REP_ERR), .MULTI_ERR(MULTI_ERR),
    .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Called at a negedge; returns at the negedge after the edge that should raise OUT_VALID.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                            input bit noise, input bit clr_vote,
                            output logic v_early, output logic v_on, output logic busy_exec);
    logic [FL-1:0] f;
    f = {op, b, a};
    for (int i = 0; i < FL; i++) begin
      READY   = (i == 0) | noise;
      DATA_IN = f[i];
      @(negedge CLK);
    end
    READY   = 1'b0;
    DATA_IN = 1'b0;
    @(negedge CLK);
    v_early   = OUT_VALID;
    busy_exec = BUSY;
    READY     = noise;
    CNT_CLR   = clr_vote;
    @(negedge CLK);
    v_on    = OUT_VALID;
    READY   = 1'b0;
    CNT_CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; DATA_IN = 1'b0; READY = 1'b0; CNT_CLR = 1'b0;
    FAULT_EN = 3'b000; FAULT_MASK = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({BUSY, OUT_VALID, OUT, OUT_MUL, COUT, REP_ERR, MULTI_ERR, ERR_CNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b out=%h mul=%h cout=%b rep=%b multi=%b cnt=%h required all 0",
               BUSY, OUT_VALID, OUT, OUT_MUL, COUT, REP_ERR, MULTI_ERR, ERR_CNT);
    end
  endtask

  task automatic test_add();
    logic ve, vo, be;
    send_frame(16'hFFFF, 16'h0001, 3'b000, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({ve, vo, be} !== 3'b011) begin
      n_fail++; $display("FAIL add_latency: got early=%b on=%b busy=%b required 0 1 1", ve, vo, be);
    end
    n_checks++;
    if ({OUT, COUT, REP_ERR, OUT_MUL} !== {16'h0000, 1'b1, 3'b000, 32'h0}) begin
      n_fail++; $display("FAIL add_result: got out=%h cout=%b rep=%b mul=%h required 0000 1 000 0", OUT, COUT, REP_ERR, OUT_MUL);
    end
    @(negedge CLK);
    n_checks++;
    if ({OUT_VALID, BUSY, OUT, COUT} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL add_pulse_hold: got valid=%b busy=%b out=%h cout=%b required 0 0 0000 1", OUT_VALID, BUSY, OUT, COUT);
    end
  endtask

  task automatic test_mul();
    logic ve, vo, be;
    send_frame(16'h00FF, 16'h0101, 3'b111, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({vo, OUT_MUL, OUT, COUT} !== {1'b1, 32'h0000FFFF, 16'hFFFF, 1'b0}) begin
      n_fail++; $display("FAIL mul_result: got valid=%b mul=%h out=%h cout=%b required 1 0000ffff ffff 0", vo, OUT_MUL, OUT, COUT);
    end
    send_frame(16'h1234, 16'h1111, 3'b000, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({OUT_MUL, OUT, COUT} !== {32'h0, 16'h2345, 1'b0}) begin
      n_fail++; $display("FAIL mul_zero_on_add: got mul=%h out=%h cout=%b required 0 2345 0", OUT_MUL, OUT, COUT);
    end
  endtask

  task automatic test_ops();
    logic ve, vo, be;
    logic [W-1:0] av [6] = '{16'h0005, 16'h1200, 16'h1234, 16'h00FF, 16'h0001, 16'hF0F0};
    logic [W-1:0] bv [6] = '{16'h0003, 16'h0034, 16'h00FF, 16'h5555, 16'h0013, 16'hFF00};
    logic [2:0]   ov [6] = '{3'b001,   3'b011,   3'b100,   3'b101,   3'b110,   3'b010};
    logic [W-1:0] ev [6] = '{16'h0002, 16'h1234, 16'h12CB, 16'hFF00, 16'h0008, 16'hF000};
    for (int i = 0; i < 6; i++) begin
      send_frame(av[i], bv[i], ov[i], 1'b0, 1'b0, ve, vo, be);
      n_checks++;
      if ({vo, OUT, COUT, OUT_MUL, REP_ERR} !== {1'b1, ev[i], 1'b0, 32'h0, 3'b000}) begin
        n_fail++; $display("FAIL ops_%0d: got valid=%b out=%h cout=%b mul=%h rep=%b required 1 %h 0 0 000",
                           i, vo, OUT, COUT, OUT_MUL, REP_ERR, ev[i]);
      end
    end
  endtask

  task automatic test_fault_single();
    logic ve, vo, be;
    FAULT_EN = 3'b010; FAULT_MASK = 16'h0001;
    send_frame(16'h0003, 16'h0005, 3'b001, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({OUT, COUT, REP_ERR, MULTI_ERR, ERR_CNT} !== {16'hFFFE, 1'b1, 3'b010, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL fault_single: got out=%h cout=%b rep=%b multi=%b cnt=%0d required fffe 1 010 0 1",
                         OUT, COUT, REP_ERR, MULTI_ERR, ERR_CNT);
    end
  endtask

  task automatic test_fault_double();
    logic ve, vo, be;
    // Two identically faulted replicas outvote the healthy one: only replica 2 is flagged.
    FAULT_EN = 3'b011; FAULT_MASK = 16'h8000;
    send_frame(16'hF0F0, 16'hFF00, 3'b010, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({OUT, REP_ERR, MULTI_ERR, ERR_CNT} !== {16'h7000, 3'b100, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL fault_double: got out=%h rep=%b multi=%b cnt=%0d required 7000 100 0 2",
                         OUT, REP_ERR, MULTI_ERR, ERR_CNT);
    end
    FAULT_EN = 3'b000; FAULT_MASK = '0;
  endtask

  task automatic test_reset_midframe();
    logic ve, vo, be, seen;
    logic [FL-1:0] f;
    f = {3'b000, 16'h0001, 16'h0002};
    for (int i = 0; i < 20; i++) begin
      READY = (i == 0); DATA_IN = f[i];
      @(negedge CLK);
    end
    READY = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if ({BUSY, OUT, OUT_MUL, COUT, REP_ERR, MULTI_ERR, ERR_CNT} !== '0) begin
      n_fail++; $display("FAIL midframe_clear: got busy=%b out=%h mul=%h cout=%b rep=%b multi=%b cnt=%h required all 0",
                         BUSY, OUT, OUT_MUL, COUT, REP_ERR, MULTI_ERR, ERR_CNT);
    end
    seen = 1'b0;
    for (int i = 0; i < FL + 5; i++) begin
      DATA_IN = f[(i + 20) % FL];
      @(negedge CLK);
      seen |= OUT_VALID | BUSY;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midframe_no_valid: got activity=%b required 0", seen);
    end
    send_frame(16'h1111, 16'h2222, 3'b000, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({vo, OUT, COUT} !== {1'b1, 16'h3333, 1'b0}) begin
      n_fail++; $display("FAIL midframe_next: got valid=%b out=%h cout=%b required 1 3333 0", vo, OUT, COUT);
    end
  endtask

  task automatic test_back_to_back();
    logic ve, vo, be;
    // READY held high through SHIFT and VOTE must not disturb framing.
    send_frame(16'h0010, 16'h0020, 3'b000, 1'b1, 1'b0, ve, vo, be);
    n_checks++;
    if ({vo, OUT} !== {1'b1, 16'h0030}) begin
      n_fail++; $display("FAIL b2b_first: got valid=%b out=%h required 1 0030", vo, OUT);
    end
    send_frame(16'h0100, 16'h0001, 3'b001, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if ({ve, vo, OUT, COUT} !== {1'b0, 1'b1, 16'h00FF, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second: got early=%b valid=%b out=%h cout=%b required 0 1 00ff 0", ve, vo, OUT, COUT);
    end
    @(negedge CLK);
    n_checks++;
    if ({BUSY, OUT_VALID} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b valid=%b required 0 0", BUSY, OUT_VALID);
    end
  endtask

  task automatic test_clear_priority();
    logic ve, vo, be;
    FAULT_EN = 3'b100; FAULT_MASK = 16'h0F00;
    send_frame(16'h0001, 16'h0001, 3'b000, 1'b0, 1'b0, ve, vo, be);
    n_checks++;
    if (ERR_CNT !== 8'd1) begin
      n_fail++; $display("FAIL clr_pre: got cnt=%0d required 1", ERR_CNT);
    end
    send_frame(16'h0001, 16'h0001, 3'b000, 1'b0, 1'b1, ve, vo, be);
    n_checks++;
    if ({ERR_CNT, REP_ERR, OUT} !== {8'd0, 3'b100, 16'h0002}) begin
      n_fail++; $display("FAIL clr_wins: got cnt=%0d rep=%b out=%h required 0 100 0002", ERR_CNT, REP_ERR, OUT);
    end
  endtask

  task automatic test_saturation();
    logic ve, vo, be;
    FAULT_EN = 3'b001; FAULT_MASK = 16'h0001;
    for (int i = 0; i < 257; i++) begin
      send_frame(16'h0002, 16'h0003, 3'b010, 1'b0, 1'b0, ve, vo, be);
      if (i == 9) begin
        n_checks++;
        if (ERR_CNT !== 8'd10) begin
          n_fail++; $display("FAIL sat_count10: got cnt=%0d required 10", ERR_CNT);
        end
      end
    end
    n_checks++;
    if (ERR_CNT !== 8'hFF) begin
      n_fail++; $display("FAIL sat_hold: got cnt=%h required ff", ERR_CNT);
    end
    FAULT_EN = 3'b000; FAULT_MASK = '0;
    CNT_CLR = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b0;
    n_checks++;
    if (ERR_CNT !== 8'h00) begin
      n_fail++; $display("FAIL sat_clear: got cnt=%h required 00", ERR_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_ops();
    test_fault_single();
    test_fault_double();
    test_reset_midframe();
    test_back_to_back();
    test_clear_priority();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
